// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the canonical NOP and the IF/ID
// pipeline register layout used by fetch, decode and the hazard unit.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DFLT = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  // A bubble doubles as the reset image of IF/ID.
  function automatic if_id_t if_id_bubble();
    if_id_t e;
    e.valid = 1'b0;
    e.instr = NOP_INSTR;
    e.pc    = '0;
    e.pc4   = 32'd4;
    return e;
  endfunction

  function automatic if_id_t if_id_entry(input logic [XLEN-1:0] instr,
                                         input logic [XLEN-1:0] pc);
    if_id_t e;
    e.valid = 1'b1;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    return e;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction response that arrives while
// the IF/ID register is frozen by a stall.
module fetch_skid_buf import cpu_pkg::*; #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            full,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  logic            full_q, full_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear || unload) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full      = full_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, one-fetch-per-cycle request to a
// 1-cycle synchronous imem, stall skid and the IF/ID pipeline register.
module if_fetch_stage import cpu_pkg::*; #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  if_id_t          if_id_q, if_id_d;

  logic            skid_load, skid_unload, skid_clear, skid_full;
  logic [XLEN-1:0] skid_instr, skid_pc;

  // No request while stalled, so a response can never meet a full skid.
  assign imem_req  = !rst && !stall && !redirect;
  assign imem_addr = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect)      pc_d = redirect_pc;
    else if (imem_req) pc_d = pc_q + XLEN'(4);

    resp_valid_d = imem_req;
    resp_pc_d    = pc_q;

    skid_clear  = redirect;
    skid_load   = !redirect && stall && resp_valid_q;
    skid_unload = !redirect && !stall && skid_full;

    if_id_d = if_id_q;
    if (redirect) begin
      if_id_d = if_id_bubble();
    end else if (!stall) begin
      if (skid_full)         if_id_d = if_id_entry(skid_instr, skid_pc);
      else if (resp_valid_q) if_id_d = if_id_entry(imem_rdata, resp_pc_q);
      else                   if_id_d = if_id_bubble();
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      if_id_q      <= if_id_bubble();
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      if_id_q      <= if_id_d;
    end
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (skid_clear),
    .in_instr  (imem_rdata),
    .in_pc     (resp_pc_q),
    .full      (skid_full),
    .out_instr (skid_instr),
    .out_pc    (skid_pc)
  );

  assign id_valid = if_id_q.valid;
  assign id_instr = if_id_q.instr;
  assign id_pc    = if_id_q.pc;
  assign id_pc4   = if_id_q.pc4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: an in-order fetch-stream model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_if_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, redirect;
  logic [31:0] redirect_pc;

  logic        imem_req, imem_req_hi;
  logic [31:0] imem_addr, imem_addr_hi, imem_rdata, imem_rdata_hi;
  logic        id_valid, id_valid_hi;
  logic [31:0] id_instr, id_instr_hi, id_pc, id_pc_hi, id_pc4, id_pc4_hi;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req_hi), .imem_addr(imem_addr_hi), .imem_rdata(imem_rdata_hi),
    .id_valid(id_valid_hi), .id_instr(id_instr_hi), .id_pc(id_pc_hi), .id_pc4(id_pc4_hi)
  );

  // Instruction memory: word at address a holds a|1; garbage when not read.
  always @(posedge clk) begin
    imem_rdata    <= imem_req    ? (imem_addr    | 32'h1) : 32'hDEAD_BEEF;
    imem_rdata_hi <= imem_req_hi ? (imem_addr_hi | 32'h1) : 32'hDEAD_BEEF;
  end

  // Fetch-stream model: addresses fetched but not yet delivered, in order.
  logic [31:0] m_pc = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_id_pc = 32'h0;
  logic [31:0] pend[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_id_pc = 32'h0; pend.delete();
    end else if (redirect) begin
      pend.delete(); m_valid = 1'b0; m_pc = redirect_pc;
    end else if (!stall) begin
      if (pend.size() > 0) begin
        m_valid = 1'b1; m_id_pc = pend.pop_front();
      end else begin
        m_valid = 1'b0;
      end
      pend.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("id_instr", id_instr, m_valid ? (m_id_pc | 32'h1) : NOP_INSTR);
    if (m_valid) begin
      chk("id_pc", id_pc, m_id_pc);
      chk("id_pc4", id_pc4, m_id_pc + 32'd4);
    end
    chk("imem_req", 32'(imem_req), 32'(!rst && !stall && !redirect));
    chk("imem_addr", imem_addr, m_pc);
    chk("inv_skid_and_resp", 32'(dut.skid_full && dut.resp_valid_q), 32'd0);
    chk("inv_load_when_full", 32'(dut.skid_load && dut.skid_full), 32'd0);
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    #1;
    cmp_model();
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic v, input logic [31:0] pc);
    chk({name, "_valid"}, 32'(id_valid), 32'(v));
    if (v) chk({name, "_pc"}, id_pc, pc);
    else   chk({name, "_instr"}, id_instr, 32'h0000_0013);
  endtask

  initial begin
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc4, 32'h4);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr_hi", imem_addr_hi, 32'hFFFF_FFF8);
    rst = 1'b0;

    // Straight-line fetch: first instruction reaches ID two cycles after release.
    step(0, 0, 0); lit("run0", 1'b0, 32'h0);
    step(0, 0, 0); lit("run1", 1'b1, 32'h0);
    chk("hi_pc0", id_pc_hi, 32'hFFFF_FFF8);
    chk("hi_instr0", id_instr_hi, 32'hFFFF_FFF9);
    step(0, 0, 0); lit("run2", 1'b1, 32'h4);
    chk("hi_pc1", id_pc_hi, 32'hFFFF_FFFC);
    chk("hi_pc4_wrap", id_pc4_hi, 32'h0);
    step(0, 0, 0); lit("run3", 1'b1, 32'h8);
    chk("hi_pc2", id_pc_hi, 32'h0);
    chk("hi_valid2", 32'(id_valid_hi), 32'd1);

    // 1-cycle stall while ID holds 8.
    step(1, 0, 0); lit("st1_hold", 1'b1, 32'h8);
    chk("st1_skid", dut.skid_pc, 32'hC);
    step(0, 0, 0); lit("st1_rel", 1'b1, 32'hC);
    step(0, 0, 0); lit("st1_next", 1'b1, 32'h10);

    // 3-cycle stall while ID holds 16.
    step(1, 0, 0); lit("st3_a", 1'b1, 32'h10);
    step(1, 0, 0); lit("st3_b", 1'b1, 32'h10);
    chk("st3_pc_hold", imem_addr, 32'h18);
    step(1, 0, 0); lit("st3_c", 1'b1, 32'h10);
    step(0, 0, 0); lit("st3_r0", 1'b1, 32'h14);
    step(0, 0, 0); lit("st3_r1", 1'b1, 32'h18);
    step(0, 0, 0); lit("st3_r2", 1'b1, 32'h1C);

    // Redirect to 0x100 while the fetch of 0x20 is in flight.
    step(0, 1, 32'h100); lit("rd_b0", 1'b0, 32'h0);
    step(0, 0, 0);       lit("rd_b1", 1'b0, 32'h0);
    step(0, 0, 0);       lit("rd_t0", 1'b1, 32'h100);
    step(0, 0, 0);       lit("rd_t1", 1'b1, 32'h104);

    // Stall fills the skid, then redirect and stall together.
    step(1, 0, 0);       lit("rs_hold", 1'b1, 32'h104);
    chk("rs_skid_full", 32'(dut.skid_full), 32'd1);
    step(1, 1, 32'h200); lit("rs_b0", 1'b0, 32'h0);
    chk("rs_skid_clr", 32'(dut.skid_full), 32'd0);
    step(0, 0, 0);       lit("rs_b1", 1'b0, 32'h0);
    step(0, 0, 0);       lit("rs_t0", 1'b1, 32'h200);
    step(0, 0, 0);       lit("rs_t1", 1'b1, 32'h204);

    // Address wrap through the top of the address space.
    step(0, 1, 32'hFFFF_FFF8); lit("wr_b0", 1'b0, 32'h0);
    step(0, 0, 0);             lit("wr_b1", 1'b0, 32'h0);
    step(0, 0, 0);             lit("wr_0", 1'b1, 32'hFFFF_FFF8);
    step(0, 0, 0);             lit("wr_1", 1'b1, 32'hFFFF_FFFC);
    chk("wr_pc4", id_pc4, 32'h0);
    step(0, 0, 0);             lit("wr_2", 1'b1, 32'h0);

    // Asynchronous reset in the middle of a stall.
    step(1, 0, 0);
    stall = 1'b1; redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_instr", id_instr, 32'h0000_0013);
    chk("arst_pc", id_pc, 32'h0);
    chk("arst_pc4", id_pc4, 32'h4);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_addr_hi", imem_addr_hi, 32'hFFFF_FFF8);
    chk("arst_skid", 32'(dut.skid_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0); lit("rr0", 1'b0, 32'h0);
    step(0, 0, 0); lit("rr1", 1'b1, 32'h0);
    step(0, 0, 0); lit("rr2", 1'b1, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end

endmodule
